// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-through/write-allocate data cache controller
module data_cache_ctrl #(
    parameter int index_count = 256,
    parameter int data        = 11,
    parameter int tag         = 20,
    localparam int IW         = $clog2(index_count),
    localparam int AW         = tag + IW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wr,
    input  logic [AW-1:0]         cpu_req_addr,
    input  logic [data-1:0]       cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [data-1:0]       cpu_rsp_rdata,
    output logic                  cache_enable,
    output logic                  rd_wr_sel,
    output logic [IW-1:0]         index_sel,
    output logic [tag+data:0]     write_index,
    output logic                  hit_miss_o,
    input  logic [tag-1:0]        cache_tag,
    input  logic                  cache_valid,
    input  logic [data-1:0]       cache_data_io,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wr,
    output logic [AW-1:0]         mem_req_addr,
    output logic [data-1:0]       mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [data-1:0]       mem_rsp_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_RD_REQ, MEM_RD_WAIT, FILL, WR_UPDATE, MEM_WR_REQ, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic              wr_q;
    logic [data-1:0]   wdata_q;
    logic [data-1:0]   rdata_q, rdata_d;
    logic              hit_miss_q;
    logic [15:0]       hit_cnt_q, miss_cnt_q;
    logic              req_ready_q, rsp_valid_q;
    logic [data-1:0]   rsp_rdata_q;
    logic              cache_en_q, rd_wr_q;
    logic [tag+data:0] write_index_q;
    logic              mem_valid_q, mem_wr_q;
    logic [AW-1:0]     mem_addr_q;
    logic [data-1:0]   mem_wdata_q;

    logic [tag-1:0]    req_tag;
    logic              lookup_hit;

    assign req_tag    = addr_q[AW-1:IW];
    assign lookup_hit = cache_valid && (cache_tag == req_tag);

    assign cpu_req_ready = req_ready_q;
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign cache_enable  = cache_en_q;
    assign rd_wr_sel     = rd_wr_q;
    assign index_sel     = addr_q[IW-1:0];
    assign write_index   = write_index_q;
    assign hit_miss_o    = hit_miss_q;
    assign mem_req_valid = mem_valid_q;
    assign mem_req_wr    = mem_wr_q;
    assign mem_req_addr  = mem_addr_q;
    assign mem_req_wdata = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

    // Next state and the word that will be returned/filled (array hit data or DRAM data)
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE:        if (cpu_req_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (wr_q) begin
                    state_d = WR_UPDATE;
                end else if (lookup_hit) begin
                    state_d = RESP;
                    rdata_d = cache_data_io;
                end else begin
                    state_d = MEM_RD_REQ;
                end
            end
            MEM_RD_REQ:  if (mem_req_ready) state_d = MEM_RD_WAIT;
            MEM_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = FILL;
                    rdata_d = mem_rsp_rdata;
                end
            end
            FILL:        state_d = RESP;
            WR_UPDATE:   state_d = MEM_WR_REQ;
            MEM_WR_REQ:  if (mem_req_ready) state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // State, request latches, counters, and outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            hit_miss_q    <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            cache_en_q    <= 1'b0;
            rd_wr_q       <= 1'b0;
            write_index_q <= '0;
            mem_valid_q   <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;

            if (state_q == IDLE && cpu_req_valid) begin
                addr_q  <= cpu_req_addr;
                wr_q    <= cpu_req_wr;
                wdata_q <= cpu_req_wdata;
            end

            if (state_q == LOOKUP) begin
                hit_miss_q <= lookup_hit;
                if (lookup_hit) begin
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end

            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            rsp_rdata_q <= (state_d == RESP && !wr_q) ? rdata_d : '0;

            cache_en_q <= (state_d == FILL) || (state_d == WR_UPDATE);
            rd_wr_q    <= (state_d == FILL) || (state_d == WR_UPDATE);
            case (state_d)
                FILL:      write_index_q <= {1'b1, req_tag, rdata_d};
                WR_UPDATE: write_index_q <= {1'b1, req_tag, wdata_q};
                default:   write_index_q <= '0;
            endcase

            mem_valid_q <= (state_d == MEM_RD_REQ) || (state_d == MEM_WR_REQ);
            mem_wr_q    <= (state_d == MEM_WR_REQ);
            mem_addr_q  <= ((state_d == MEM_RD_REQ) || (state_d == MEM_WR_REQ)) ? addr_q : '0;
            mem_wdata_q <= (state_d == MEM_WR_REQ) ? wdata_q : '0;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - scoreboard bench for data_cache_ctrl with array and DRAM models
module tb_data_cache_ctrl;
    localparam int IC = 256;
    localparam int DW = 11;
    localparam int TW = 20;
    localparam int IW = 8;
    localparam int AW = 28;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req_valid, cpu_req_ready, cpu_req_wr;
    logic [AW-1:0]   cpu_req_addr;
    logic [DW-1:0]   cpu_req_wdata;
    logic            cpu_rsp_valid;
    logic [DW-1:0]   cpu_rsp_rdata;
    logic            cache_enable, rd_wr_sel;
    logic [IW-1:0]   index_sel;
    logic [TW+DW:0]  write_index;
    logic            hit_miss_o;
    logic [TW-1:0]   cache_tag;
    logic            cache_valid;
    logic [DW-1:0]   cache_data_io;
    logic            mem_req_valid, mem_req_ready, mem_req_wr;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_rdata;
    logic [15:0]     hit_count, miss_count;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_cache_ctrl #(.index_count(IC), .data(DW), .tag(TW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cache_enable(cache_enable), .rd_wr_sel(rd_wr_sel), .index_sel(index_sel),
        .write_index(write_index), .hit_miss_o(hit_miss_o),
        .cache_tag(cache_tag), .cache_valid(cache_valid), .cache_data_io(cache_data_io),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // data_cache array: combinational read at index_sel, clocked write, valid cleared by rst
    logic            arr_v [IC];
    logic [TW-1:0]   arr_t [IC];
    logic [DW-1:0]   arr_d [IC];
    assign cache_valid   = arr_v[index_sel];
    assign cache_tag     = arr_t[index_sel];
    assign cache_data_io = arr_d[index_sel];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IC; i++) arr_v[i] <= 1'b0;
        end else if (cache_enable && rd_wr_sel) begin
            arr_v[index_sel] <= write_index[TW+DW];
            arr_t[index_sel] <= write_index[TW+DW-1:DW];
            arr_d[index_sel] <= write_index[DW-1:0];
        end
    end

    typedef struct {
        logic           wr;
        logic [DW-1:0]  rdata;
        logic           hit;
        int             hc;
        int             mc;
        int             acc;
        int             lat;
        logic [TW+DW:0] wi;
        logic [IW-1:0]  idx;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mexp_t;

    exp_t  sb[$];
    mexp_t mq[$];

    logic [DW-1:0] dram [logic [AW-1:0]];
    logic          ref_v [IC];
    logic [TW-1:0] ref_t [IC];
    int hcnt = 0, mcnt = 0;

    int cfg_stall = 0, cfg_dly = 1;
    int stall_left = 0, pend = 0;
    logic [DW-1:0] pend_data;
    logic in_req = 1'b0;
    logic [AW+DW:0] prev_req;
    int last_rsp_cyc = -100, mem_hs_cyc = -1;
    int arr_writes = 0;

    // DRAM model plus response/array-write monitor, all sampled mid-cycle
    always @(negedge clk) begin
        mexp_t m;
        exp_t  e;
        int    exp_cyc;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = pend_data;
                last_rsp_cyc  = cyc;
            end
        end
        if (mem_req_valid) begin
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = cfg_stall;
            end else begin
                check("mem_req_stable", {mem_req_wr, mem_req_addr, mem_req_wdata}, prev_req);
            end
            if (stall_left > 0) begin
                stall_left--;
                mem_req_ready = 1'b0;
                prev_req      = {mem_req_wr, mem_req_addr, mem_req_wdata};
            end else begin
                mem_req_ready = 1'b1;
                in_req        = 1'b0;
                mem_hs_cyc    = cyc;
                check("mem_req_expected", 64'(mq.size() != 0), 1);
                if (mq.size() != 0) begin
                    m = mq.pop_front();
                    check("mem_req_wr", mem_req_wr, m.wr);
                    check("mem_req_addr", mem_req_addr, m.addr);
                    if (m.wr) check("mem_req_wdata", mem_req_wdata, m.wdata);
                end
                if (mem_req_wr) begin
                    dram[mem_req_addr] = mem_req_wdata;
                end else begin
                    pend      = cfg_dly;
                    pend_data = dram.exists(mem_req_addr) ? dram[mem_req_addr] : '0;
                end
            end
        end else begin
            mem_req_ready = 1'b0;
            in_req        = 1'b0;
        end

        if (cache_enable && rd_wr_sel) begin
            arr_writes++;
            check("array_wr_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("array_wr_word", write_index, sb[0].wi);
                check("array_wr_index", index_sel, sb[0].idx);
            end
        end

        if (cpu_rsp_valid) begin
            check("rsp_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_rdata", cpu_rsp_rdata, e.rdata);
                check("hit_miss_o", hit_miss_o, e.hit);
                check("hit_count", hit_count, e.hc);
                check("miss_count", miss_count, e.mc);
                exp_cyc = (e.lat >= 0) ? e.acc + e.lat : last_rsp_cyc + 2;
                check("rsp_cycle", cyc, exp_cyc);
                check("array_writes", arr_writes, (e.wr || !e.hit) ? 1 : 0);
            end
            arr_writes = 0;
        end
    end

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic drive_and_accept(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                    output int acc);
        int n = 0;
        cpu_req_valid = 1'b1;
        cpu_req_wr    = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        while (!cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", cpu_req_ready, 1);
        acc = cyc;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_wr    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int stall, input int dly);
        exp_t          e;
        mexp_t         m;
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        int            n;
        int            acc;
        idx = addr[IW-1:0];
        tg  = addr[AW-1:IW];
        @(negedge clk);
        cfg_stall = stall;
        cfg_dly   = dly;
        if (!wr && !dram.exists(addr)) dram[addr] = DW'($urandom);
        e.hit = ref_v[idx] && (ref_t[idx] == tg);
        if (e.hit) hcnt++; else mcnt++;
        e.hc    = sat(hcnt);
        e.mc    = sat(mcnt);
        e.wr    = wr;
        e.rdata = wr ? '0 : dram[addr];
        e.wi    = {1'b1, tg, wr ? wd : dram[addr]};
        e.idx   = idx;
        e.lat   = wr ? 4 + stall : (e.hit ? 2 : -1);
        if (wr || !e.hit) begin
            m.wr = wr; m.addr = addr; m.wdata = wd;
            mq.push_back(m);
        end
        ref_v[idx] = 1'b1;
        ref_t[idx] = tg;
        cpu_req_valid = 1'b1;
        cpu_req_wr    = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        n = 0;
        while (!cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", cpu_req_ready, 1);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", sb.size(), 0);
        if (sb.size() != 0) begin
            sb.delete();
            mq.delete();
        end
    endtask

    initial begin
        #40000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            hs0;
        int            acc;
        mexp_t         m;
        logic [AW-1:0] a;
        for (int i = 0; i < IC; i++) ref_v[i] = 1'b0;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_wr = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_req_ready", cpu_req_ready, 1);
        check("rst_rsp_valid", cpu_rsp_valid, 0);
        check("rst_rsp_rdata", cpu_rsp_rdata, 0);
        check("rst_cache_en", {cache_enable, rd_wr_sel}, 0);
        check("rst_write_index", write_index, 0);
        check("rst_index_sel", index_sel, 0);
        check("rst_hit_miss", hit_miss_o, 0);
        check("rst_mem_req", {mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata}, 0);
        check("rst_counters", {hit_count, miss_count}, 0);

        dram[28'h00ABC05] = 11'h2AB;
        dram[28'h0123405] = 11'h155;
        do_req(1'b0, 28'h00ABC05, '0, 0, 3);
        check("line5_tag_abc", {arr_v[5], arr_t[5], arr_d[5]}, {1'b1, 20'h00ABC, 11'h2AB});
        do_req(1'b0, 28'h00ABC05, '0, 0, 3);
        do_req(1'b0, 28'h0123405, '0, 1, 2);
        check("line5_tag_1234", arr_t[5], 20'h01234);
        do_req(1'b1, 28'h0123405, 11'h7FF, 4, 1);
        do_req(1'b0, 28'h0123405, '0, 0, 1);

        // Reset while waiting on DRAM read data; the response arrives after reset
        @(negedge clk);
        cfg_stall = 0;
        cfg_dly   = 4;
        m.wr = 1'b0; m.addr = 28'h00ABC05; m.wdata = '0;
        mq.push_back(m);
        hs0 = mem_hs_cyc;
        drive_and_accept(1'b0, 28'h00ABC05, '0, acc);
        n = 0;
        while (mem_hs_cyc == hs0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_mem_hs", 64'(mem_hs_cyc != hs0), 1);
        while (cyc < mem_hs_cyc + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", cpu_req_ready, 1);
        check("abort_mem_valid", mem_req_valid, 0);
        check("abort_counters", {hit_count, miss_count}, 0);
        check("abort_hit_miss", hit_miss_o, 0);
        for (int i = 0; i < IC; i++) ref_v[i] = 1'b0;
        hcnt = 0;
        mcnt = 0;
        repeat (6) @(negedge clk);
        check("stale_rsp_ignored", {cpu_req_ready, cache_enable}, 2'b10);
        do_req(1'b0, 28'h00ABC05, '0, 0, 2);

        for (int k = 0; k < 200; k++) begin
            a = {20'($urandom_range(0, 3) * 20'h11111), 8'($urandom_range(0, 3))};
            do_req(($urandom_range(0, 2) == 0), a, DW'($urandom),
                   $urandom_range(0, 3), $urandom_range(1, 4));
        end

        do_req(1'b0, 28'h00ABC05, '0, 0, 1);
        for (int k = 0; k < 65540; k++) do_req(1'b0, 28'h00ABC05, '0, 0, 1);
        check("hit_count_saturated", hit_count, 16'hFFFF);
        do_req(1'b0, 28'h00ABC05, '0, 0, 1);
        check("hit_count_held", hit_count, 16'hFFFF);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
